pipe_mem_arbiter: RTL
=====================

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, max cycles a memory transaction waits for mem_ack before abort.
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  fetch stage requests an instruction word.
REQ-005 i_addr  input  32  fetch address (PC).
REQ-006 mm2reg  input  1  MEM-stage instruction is a load.
REQ-007 mwmem  input  1  MEM-stage instruction is a store.
REQ-008 malu  input  32  MEM-stage data address.
REQ-009 mb  input  32  MEM-stage store data.
REQ-010 i_rdata  output  32  fetched instruction, valid in the cycle i_stall is low with i_req high.
REQ-011 d_rdata  output  32  load data, valid in the cycle d_stall is low with mm2reg high.
REQ-012 i_stall  output  1  freezes PC and the IF/ID register.
REQ-013 d_stall  output  1  freezes the entire pipeline.
REQ-014 mem_req, mem_we  output  1 each  request to, and write enable of, the single-port memory.
REQ-015 mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-016 mem_ack  input  1  memory completes the current request in this cycle.
REQ-017 mem_rdata  input  32  read data, valid when mem_ack is high.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 FSM states IDLE, DATA, FETCH; d_active = mm2reg | mwmem.
REQ-020 IDLE: d_active -> DATA; else i_req -> FETCH; else stay.
REQ-021 d_active and i_req both high in IDLE -> DATA, because the older instruction has priority.
REQ-022 Non-preemptive: d_active rising during FETCH does not abort the fetch; DATA is issued after the fetch returns to IDLE.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata are registered and are driven from the cycle after the IDLE decision.
- DATA: mem_addr=malu, mem_we=mwmem, mem_wdata=mb.
- FETCH: mem_addr=i_addr, mem_we=0.
REQ-024 mem_req and all memory outputs hold stable until the cycle mem_ack=1.
REQ-025 mem_ack with mem_req high: the FSM returns to IDLE at the next edge, and mem_req drops at that edge.
REQ-026 Minimum access latency: 2 cycles (decision cycle + ack cycle).
REQ-027 mem_ack while mem_req is low is ignored.
REQ-028 d_stall = d_active & ~(state==DATA & mem_ack) & ~abort.
REQ-029 i_stall = d_stall | (i_req & ~(state==FETCH & mem_ack) & ~abort).
REQ-030 i_rdata and d_rdata are combinational copies of mem_rdata when acked, 0 on abort.
REQ-031 Wait counter: cleared on entry to DATA/FETCH, increments each non-ack cycle.
REQ-032 abort = counter == ACK_TIMEOUT-1 without ack; abort forces the FSM to IDLE, drops mem_req, releases the stall for that cycle and sets err.
REQ-033 err clears only on reset.
REQ-034 A store is issued exactly once per MEM-stage instruction, with no reissue after ack.

Reset
REQ-035 clrn low, at any time including mid-transaction: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, err=0.
REQ-036 The combinational outputs follow from the reset state.
REQ-037 An outstanding memory request is abandoned on reset; the memory is reset by the same clrn.

Structure
REQ-038 Package pipe_mem_pkg holds the state enum (IDLE, DATA, FETCH) and the default ACK_TIMEOUT constant.
REQ-039 Sub-module pipe_mem_wdog holds the wait counter and abort generation, parameterised by ACK_TIMEOUT.

Verification
REQ-040 Fetch only, ack 1 cycle after mem_req, i_addr=0x40, mem_rdata=0x8C410004 -> i_stall high 1 cycle, then i_rdata=0x8C410004, mem_we=0.
REQ-041 Store only, malu=0x100, mb=0xDEADBEEF, ack after 3 cycles -> mem_we=1 and mem_addr/mem_wdata stable for 3 cycles, d_stall and i_stall high until the ack cycle, exactly one write.
REQ-042 Load and fetch simultaneous in IDLE -> DATA is served first, then FETCH; i_stall stays high through both; d_rdata equals mem_rdata at the first ack.
REQ-043 Load arriving during an active FETCH -> fetch completes unaborted, then the load issues on the next IDLE cycle.
REQ-044 No ack with ACK_TIMEOUT=16 -> abort after 16 cycles in DATA, err=1 and sticky, stalls drop, d_rdata=0, FSM in IDLE.
REQ-045 clrn pulsed low mid-DATA -> mem_req drops immediately, err=0, state IDLE, a fresh request issues after release.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_mem_pkg
// Brief   : Shared types and defaults for the pipeline memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_mem_pkg;

  localparam int ACK_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_mem_wdog.sv
`default_nettype none
// ============================================================================
// Module  : pipe_mem_wdog
// Brief   : Counts unacknowledged cycles of a memory access and flags abort.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_mem_wdog #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clrn,
  input  logic busy_i,
  input  logic ack_i,
  output logic abort_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Held at zero while idle, so every access starts counting from zero.
  assign abort_o = busy_i & ~ack_i & (cnt_q == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i || ack_i || abort_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : pipe_mem_arbiter
// Brief   : Non-preemptive arbiter sharing one memory port between IF and MEM.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_mem_arbiter #(
  parameter int ACK_TIMEOUT = pipe_mem_pkg::ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic        i_stall,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  import pipe_mem_pkg::*;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        err_q;

  logic d_active;
  logic ack_v;
  logic abort;
  logic data_ack;
  logic fetch_ack;

  assign d_active  = mm2reg | mwmem;
  // A stray ack with no request outstanding must not complete anything.
  assign ack_v     = mem_ack & mem_req_q;
  assign data_ack  = (state_q == DATA) & ack_v;
  assign fetch_ack = (state_q == FETCH) & ack_v;

  pipe_mem_wdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .clrn    (clrn),
    .busy_i  (state_q != IDLE),
    .ack_i   (ack_v),
    .abort_o (abort)
  );

  assign d_stall = d_active & ~data_ack & ~abort;
  assign i_stall = d_stall | (i_req & ~fetch_ack & ~abort);
  assign d_rdata = data_ack  ? mem_rdata : 32'd0;
  assign i_rdata = fetch_ack ? mem_rdata : 32'd0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        // The MEM-stage instruction is older, so it wins over the fetch.
        if (d_active) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = mwmem;
          mem_addr_d  = malu;
          mem_wdata_d = mb;
        end else if (i_req) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
        end
      end
      DATA, FETCH: begin
        if (ack_v || abort) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
